alu_operand_stage: RTL and testbench

//  Operand-fetch pipeline stage that feeds alu_add/alu_sub: holds the integer register file
//  and reads two source registers per instruction. It presents registered rs1/rs2 operand

---
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 tb/tb_alu_operand_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : Operand-fetch stage in front of the ALU. It holds the integer
//             register file and reads two source registers per instruction.
//             It presents the registered operands, rd and opcode to the ALU
//             under a valid/ready handshake with a single output slot.
//             Same-cycle writeback bypass and stall-time operand refresh keep
//             the operands seen by the ALU up to date.
//  Ports    : clk, reset (async, active-low)
//             in_valid/in_ready, in_rs1_addr, in_rs2_addr, in_rd_addr, in_op
//             wb_en, wb_addr, wb_data            (retire-stage writeback)
//             out_valid/out_ready, out_rs1, out_rs2, out_rd_addr, out_op
//  Revision : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rs1_addr,
    input  logic [AW-1:0]   in_rs2_addr,
    input  logic [AW-1:0]   in_rd_addr,
    input  logic [OPW-1:0]  in_op,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [AW-1:0]   out_rd_addr,
    output logic [OPW-1:0]  out_op
);

    logic [XLEN-1:0] rf_q [NREG];

    logic            valid_q;
    logic [XLEN-1:0] rs1_q,  rs1_d;
    logic [XLEN-1:0] rs2_q,  rs2_d;
    logic [AW-1:0]   rd_q;
    logic [OPW-1:0]  op_q;
    logic [AW-1:0]   hrs1_q;
    logic [AW-1:0]   hrs2_q;

    logic            w_accept;
    logic            w_wb_live;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign in_ready  = !valid_q || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_wb_live = wb_en && (wb_addr != '0);

    // x0 reads as zero; a writeback landing this cycle wins over the array.
    always_comb begin
        w_rd1 = rf_q[in_rs1_addr];
        if (in_rs1_addr == '0) begin
            w_rd1 = '0;
        end else if (w_wb_live && (wb_addr == in_rs1_addr)) begin
            w_rd1 = wb_data;
        end
    end

    always_comb begin
        w_rd2 = rf_q[in_rs2_addr];
        if (in_rs2_addr == '0) begin
            w_rd2 = '0;
        end else if (w_wb_live && (wb_addr == in_rs2_addr)) begin
            w_rd2 = wb_data;
        end
    end

    // Operand next-state: load on accept, otherwise refresh a held operand
    // whose source register is being written back right now.
    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (w_accept) begin
            rs1_d = w_rd1;
            rs2_d = w_rd2;
        end else if (valid_q && w_wb_live) begin
            if (wb_addr == hrs1_q) begin
                rs1_d = wb_data;
            end
            if (wb_addr == hrs2_q) begin
                rs2_d = wb_data;
            end
        end
    end

    // Register file; entry 0 is never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (w_wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            hrs1_q  <= '0;
            hrs2_q  <= '0;
        end else begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            if (w_accept) begin
                valid_q <= 1'b1;
                rd_q    <= in_rd_addr;
                op_q    <= in_op;
                hrs1_q  <= in_rs1_addr;
                hrs2_q  <= in_rs2_addr;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_rs1     = rs1_q;
    assign out_rs2     = rs2_q;
    assign out_rd_addr = rd_q;
    assign out_op      = op_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_operand_stage
//  Purpose  : Self-checking bench for alu_operand_stage using a reference
//             register file and a scoreboard of expected output instructions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_op;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1, out_rs2;
    logic [4:0]  out_rd_addr;
    logic [3:0]  out_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] mrf [32];

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(32), .NREG(32), .AW(5), .OPW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1_addr (in_rs1_addr),
        .in_rs2_addr (in_rs2_addr),
        .in_rd_addr  (in_rd_addr),
        .in_op       (in_op),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd_addr (out_rd_addr),
        .out_op      (out_op)
    );

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)                          return 32'd0;
        if (wb_en && wb_addr != 5'd0 && wb_addr == a) return wb_data;
        return mrf[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        sb.delete();
    endtask

    task automatic drive(input logic iv, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic [3:0] op, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
        in_valid = iv; in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd; in_op = op;
        wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    endtask

    // Checks the current cycle against the scoreboard, advances the model,
    // then steps one clock and returns at the following falling edge.
    task automatic cycle();
        entry_t e;
        logic   acc;
        logic   exp_rdy;
        #1;
        exp_rdy = (sb.size() == 0) || out_ready;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready got %b expected %b @%0t", in_ready, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL out_valid got %b expected %b @%0t", out_valid, sb.size() != 0, $time);
        end
        if (sb.size() != 0) begin
            checks++;
            if (out_rs1 !== sb[0].rs1 || out_rs2 !== sb[0].rs2 ||
                out_rd_addr !== sb[0].rd || out_op !== sb[0].op) begin
                errors++;
                $display("FAIL outputs got rs1=%h rs2=%h rd=%0d op=%0d expected rs1=%h rs2=%h rd=%0d op=%0d @%0t",
                         out_rs1, out_rs2, out_rd_addr, out_op,
                         sb[0].rs1, sb[0].rs2, sb[0].rd, sb[0].op, $time);
            end
        end
        acc = in_valid && exp_rdy;
        if (sb.size() != 0 && !acc && wb_en && wb_addr != 5'd0) begin
            if (wb_addr == sb[0].a1) sb[0].rs1 = wb_data;
            if (wb_addr == sb[0].a2) sb[0].rs2 = wb_data;
        end
        if (sb.size() != 0 && out_ready) void'(sb.pop_front());
        if (acc) begin
            e.rs1 = model_read(in_rs1_addr);
            e.rs2 = model_read(in_rs2_addr);
            e.rd  = in_rd_addr;
            e.op  = in_op;
            e.a1  = in_rs1_addr;
            e.a2  = in_rs2_addr;
            sb.push_back(e);
        end
        if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 1'b1);
            cycle();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_rs1 !== 32'd0 || out_rs2 !== 32'd0 ||
            out_rd_addr !== 5'd0 || out_op !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b rs1=%h rs2=%h rd=%0d op=%0d expected all 0",
                     out_valid, out_rs1, out_rs2, out_rd_addr, out_op);
        end
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_zero_regs();
        drive(1'b1, 5'd3, 5'd4, 5'd1, 4'd2, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        idle(2);
    endtask

    task automatic test_writeback_read();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 5'd3, 32'd71, 1'b1);
        cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 5'd4, 32'hFFFF_FFAE, 1'b1);
        cycle();
        drive(1'b1, 5'd3, 5'd4, 5'd5, 4'd1, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || (out_rs1 + out_rs2) !== 32'hFFFF_FFF5) begin
            errors++;
            $display("FAIL alu_sum got v=%b sum=%h expected v=1 sum=fffffff5",
                     out_valid, out_rs1 + out_rs2);
        end
        idle(2);
    endtask

    task automatic test_bypass();
        drive(1'b1, 5'd7, 5'd0, 5'd2, 4'd3, 1'b1, 5'd7, 32'd82, 1'b1);
        cycle();
        drive(1'b1, 5'd7, 5'd7, 5'd2, 4'd4, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        idle(2);
    endtask

    task automatic test_stall_refresh();
        drive(1'b1, 5'd9, 5'd9, 5'd6, 4'd5, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 5'd3, 5'd8, 4'd6, 1'b1, 5'd9, 32'hFFFF_FFFF, 1'b0);
        cycle();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready got %b expected 0", in_ready);
        end
        drive(1'b1, 5'd3, 5'd4, 5'd8, 4'd6, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        drive(1'b1, 5'd3, 5'd4, 5'd8, 4'd6, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_rd_addr !== 5'd8 || out_rs1 !== 32'd71) begin
            errors++;
            $display("FAIL no_bubble got v=%b rd=%0d rs1=%h expected v=1 rd=8 rs1=00000047",
                     out_valid, out_rd_addr, out_rs1);
        end
        idle(2);
    endtask

    task automatic test_x0();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
        cycle();
        drive(1'b1, 5'd0, 5'd0, 5'd1, 4'd7, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
        cycle();
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0));
            cycle();
        end
        idle(2);
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd3, 5'd9, 5'd4, 4'd9, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_rs1 !== 32'd0 || out_rs2 !== 32'd0 ||
            out_rd_addr !== 5'd0 || out_op !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b rs1=%h rs2=%h rd=%0d op=%0d expected all 0",
                     out_valid, out_rs1, out_rs2, out_rd_addr, out_op);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 5'd3, 5'd9, 5'd1, 4'd1, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        drive(1'b1, 5'd7, 5'd4, 5'd2, 4'd2, 1'b0, 5'd0, 32'd0, 1'b1);
        cycle();
        idle(2);
    endtask

    initial begin
        test_reset();
        test_zero_regs();
        test_writeback_read();
        test_bypass();
        test_stall_refresh();
        test_x0();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
